// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the forwarding/hazard controller: mux selects,
// FSM states and the per-stage shadow record.
package pipe_ctrl_pkg;

  localparam logic [2:0] SEL_RF    = 3'd0;
  localparam logic [2:0] SEL_EXMEM = 3'd1;
  localparam logic [2:0] SEL_MEMWB = 3'd2;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } ctrlState_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } stageRec_t;

  localparam stageRec_t EMPTY_REC = '{valid: 1'b0, rd: 5'd0, regwrite: 1'b0, memread: 1'b0};

  // True when the stage will write a non-zero register equal to src.
  function automatic logic writesReg(input stageRec_t rec, input logic [4:0] src);
    return rec.valid && rec.regwrite && (rec.rd != 5'd0) && (rec.rd == src);
  endfunction

endpackage

// File: rtl/fwd_compare.sv
// Picks the ALU operand source for one ID source register; the younger
// producer (EX) wins over the older one (MEM).
module fwd_compare
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       useSrc,
  input  stageRec_t  exRec,
  input  stageRec_t  memRec,
  output logic [2:0] sel
);

  always_comb begin
    sel = SEL_RF;
    if (useSrc) begin
      if (writesReg(exRec, src)) begin
        sel = SEL_EXMEM;
      end else if (writesReg(memRec, src)) begin
        sel = SEL_MEMWB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for a 5-stage pipeline.
// State | meaning
// RUN    | normal issue; a load-use hit stalls IF/ID and bubbles ID/EX
// BUBBLE | the injected bubble is in EX; the held instruction re-issues
module fwd_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic [4:0]  id_rd,
  output logic [2:0]  ForwardA_sel,
  output logic [2:0]  ForwardB_sel,
  output logic        stall,
  output logic        flush_idex,
  output logic [15:0] stall_count
);

  stageRec_t  exRec, memRec, wbRec, idRec;
  ctrlState_t state, stateNext;
  logic       loadUse;
  logic [2:0] selARaw, selBRaw;

  assign idRec = '{valid: id_valid, rd: id_rd,
                   regwrite: id_regwrite & id_valid,
                   memread: id_memread & id_valid};

  fwd_compare uCmpA (
    .src    (id_rs),
    .useSrc (id_valid & id_uses_rs),
    .exRec  (exRec),
    .memRec (memRec),
    .sel    (selARaw)
  );

  fwd_compare uCmpB (
    .src    (id_rt),
    .useSrc (id_valid & id_uses_rt),
    .exRec  (exRec),
    .memRec (memRec),
    .sel    (selBRaw)
  );

  always_comb begin
    loadUse = 1'b0;
    if (id_valid && exRec.valid && exRec.memread && exRec.regwrite && (exRec.rd != 5'd0)) begin
      loadUse = (id_uses_rs && (id_rs == exRec.rd)) || (id_uses_rt && (id_rt == exRec.rd));
    end
  end

  // Rst gates the stall so a reset landing mid-hazard takes effect at once.
  always_comb begin
    stateNext  = state;
    stall      = 1'b0;
    flush_idex = 1'b0;
    case (state)
      RUN: begin
        if (loadUse && !Rst) begin
          stall      = 1'b1;
          flush_idex = 1'b1;
          stateNext  = BUBBLE;
        end
      end
      BUBBLE:  stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= RUN;
      exRec        <= EMPTY_REC;
      memRec       <= EMPTY_REC;
      wbRec        <= EMPTY_REC;
      ForwardA_sel <= SEL_RF;
      ForwardB_sel <= SEL_RF;
      stall_count  <= 16'd0;
    end else begin
      state        <= stateNext;
      exRec        <= flush_idex ? EMPTY_REC : idRec;
      memRec       <= exRec;
      wbRec        <= memRec;
      ForwardA_sel <= flush_idex ? SEL_RF : selARaw;
      ForwardB_sel <= flush_idex ? SEL_RF : selBRaw;
      if (stall && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed and randomized checks of fwd_hazard_ctrl against an
// instruction-history reference model.
module tb_fwd_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0;
  logic        id_regwrite = 1'b0, id_memread = 1'b0;
  logic [2:0]  ForwardA_sel, ForwardB_sel;
  logic        stall, flush_idex;
  logic [15:0] stall_count;

  fwd_hazard_ctrl dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .id_rd        (id_rd),
    .ForwardA_sel (ForwardA_sel),
    .ForwardB_sel (ForwardB_sel),
    .stall        (stall),
    .flush_idex   (flush_idex),
    .stall_count  (stall_count)
  );

  always #5 Clk = ~Clk;

  // hist[0] = instruction now in EX, hist[1] = instruction now in MEM
  typedef struct {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } instr_t;

  instr_t     hist[2];
  logic [2:0] expA, expB;
  int         expCount;
  int         nPass = 0;
  int         nTotal = 0;
  logic       obsStall;
  logic       lastHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTotal++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [2:0] modelSel(input logic v, input logic hz, input logic u,
                                          input logic [4:0] src);
    if (!v || hz || !u || src == 5'd0) return 3'd0;
    if (hist[0].valid && hist[0].wr && hist[0].rd == src) return 3'd1;
    if (hist[1].valid && hist[1].wr && hist[1].rd == src) return 3'd2;
    return 3'd0;
  endfunction

  task automatic modelReset();
    hist[0] = '{1'b0, 5'd0, 1'b0, 1'b0};
    hist[1] = '{1'b0, 5'd0, 1'b0, 1'b0};
    expA = 3'd0;
    expB = 3'd0;
    expCount = 0;
  endtask

  task automatic doReset();
    Rst = 1'b1;
    id_valid = 1'b0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_regwrite = 1'b0; id_memread = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    modelReset();
    chk("rst_selA", ForwardA_sel, 3'd0);
    chk("rst_selB", ForwardB_sel, 3'd0);
    chk("rst_count", stall_count, 16'd0);
    chk("rst_stall", stall, 1'b0);
  endtask

  // One ID cycle: drive, check combinational hazard outputs, clock, check registered outputs.
  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic ur, input logic ut,
                      input logic wr, input logic ld);
    logic hz;
    logic [2:0] na, nb;
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = ur; id_uses_rt = ut; id_regwrite = wr; id_memread = ld;
    #1;
    hz = v && hist[0].valid && hist[0].ld && hist[0].wr && (hist[0].rd != 5'd0) &&
         ((ur && rs == hist[0].rd) || (ut && rt == hist[0].rd));
    obsStall = stall;
    lastHz = hz;
    chk("stall", stall, hz);
    chk("flush_idex", flush_idex, hz);
    na = modelSel(v, hz, ur, rs);
    nb = modelSel(v, hz, ut, rt);
    @(posedge Clk); #1;
    hist[1] = hist[0];
    if (v && !hz) hist[0] = '{1'b1, rd, wr, ld};
    else          hist[0] = '{1'b0, 5'd0, 1'b0, 1'b0};
    if (hz && expCount < 65535) expCount++;
    expA = na;
    expB = nb;
    chk("selA", ForwardA_sel, expA);
    chk("selB", ForwardB_sel, expB);
    chk("stall_count", stall_count, expCount);
  endtask

  initial begin
    logic       v, ur, ut, wr, ld;
    logic [4:0] rs, rt, rd;

    modelReset();
    doReset();

    // add $3 then a reader of $3 -> EX/MEM forward
    step(1, 0, 0, 3, 0, 0, 1, 0);
    step(1, 3, 0, 4, 1, 0, 1, 0);
    chk("ex_fwd_stall", obsStall, 1'b0);
    chk("ex_fwd_selA", ForwardA_sel, 3'd1);

    // $5 two back -> MEM/WB; $5 in both -> EX/MEM wins
    step(1, 0, 0, 5, 0, 0, 1, 0);
    step(1, 0, 0, 6, 0, 0, 1, 0);
    step(1, 0, 5, 7, 0, 1, 1, 0);
    chk("mem_fwd_selB", ForwardB_sel, 3'd2);
    step(1, 0, 0, 5, 0, 0, 1, 0);
    step(1, 0, 0, 5, 0, 0, 1, 0);
    step(1, 0, 5, 7, 0, 1, 1, 0);
    chk("prio_selB", ForwardB_sel, 3'd1);

    // lw $8 then add using $8: one stall, then MEM/WB forward
    step(1, 0, 0, 8, 0, 0, 1, 1);
    step(1, 8, 0, 9, 1, 0, 1, 0);
    chk("lu_stall", obsStall, 1'b1);
    chk("lu_bubble_selA", ForwardA_sel, 3'd0);
    step(1, 8, 0, 9, 1, 0, 1, 0);
    chk("lu_second_stall", obsStall, 1'b0);
    chk("lu_selA", ForwardA_sel, 3'd2);
    chk("lu_count", stall_count, 16'd1);

    // $0 never forwarded; unused rt never forwarded; lw $0 never stalls
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 4, 1, 0, 1, 0);
    chk("r0_selA", ForwardA_sel, 3'd0);
    step(1, 0, 0, 7, 0, 0, 1, 0);
    step(1, 0, 7, 4, 0, 0, 1, 0);
    chk("unused_selB", ForwardB_sel, 3'd0);
    step(1, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 4, 1, 0, 1, 0);
    chk("lw_r0_stall", obsStall, 1'b0);

    // reset in the middle of a load-use stall
    step(1, 0, 0, 10, 0, 0, 1, 1);
    id_valid = 1; id_rs = 10; id_rt = 0; id_rd = 11;
    id_uses_rs = 1; id_uses_rt = 0; id_regwrite = 1; id_memread = 0;
    #1;
    chk("pre_rst_stall", stall, 1'b1);
    Rst = 1'b1;
    #1;
    chk("in_rst_stall", stall, 1'b0);
    chk("in_rst_flush", flush_idex, 1'b0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    modelReset();
    chk("post_rst_stall", stall, 1'b0);
    chk("post_rst_flush", flush_idex, 1'b0);
    chk("post_rst_selA", ForwardA_sel, 3'd0);
    chk("post_rst_selB", ForwardB_sel, 3'd0);
    chk("post_rst_count", stall_count, 16'd0);

    // randomized traffic; a stalled instruction is re-presented
    lastHz = 1'b0;
    v = 0; rs = 0; rt = 0; rd = 0; ur = 0; ut = 0; wr = 0; ld = 0;
    for (int i = 0; i < 400; i++) begin
      if (!lastHz) begin
        v  = ($urandom_range(0, 9) < 8);
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        ur = 1'($urandom_range(0, 1));
        ut = 1'($urandom_range(0, 1));
        wr = ($urandom_range(0, 3) != 0);
        ld = wr && ($urandom_range(0, 2) == 0);
      end
      step(v, rs, rt, rd, ur, ut, wr, ld);
    end

    // back-to-back loads chained through $8: a stall every other cycle
    doReset();
    id_valid = 1; id_rs = 8; id_rt = 0; id_rd = 8;
    id_uses_rs = 1; id_uses_rt = 0; id_regwrite = 1; id_memread = 1;
    repeat (2 * 65534) @(posedge Clk);
    #1;
    chk("sat_pre", stall_count, 16'hFFFE);
    repeat (12) @(posedge Clk);
    #1;
    chk("sat_hold", stall_count, 16'hFFFF);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have ports: Clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: Rst  in  1  synchronous, active-high reset, sampled on rising Clk.
REQ-003 SHALL have: id_valid  in  1  ID stage holds a real instruction.
REQ-004 SHALL have: id_rs, id_rt  in  5 each  source register numbers of the ID instruction.
REQ-005 SHALL have: id_uses_rs, id_uses_rt  in  1 each  ID instruction reads that source.
REQ-006 SHALL have: id_regwrite, id_memread  in  1 each  ID instruction writes a register / is a load.
REQ-007 SHALL have: id_rd  in  5  destination register of the ID instruction.
REQ-008 SHALL have: ForwardA_sel, ForwardB_sel  out  3 each  ALU input mux selects for the EX instruction; 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result.
REQ-009 SHALL have: stall  out  1  hold PC and IF/ID this cycle.
REQ-010 SHALL have: flush_idex  out  1  load a bubble into ID/EX this cycle.
REQ-011 SHALL have: stall_count  out  16  count of load-use stall cycles since reset.

Function
REQ-012 SHALL keep shadow records for EX, MEM and WB stages: {valid, rd, regwrite, memread}; they advance every Clk.
REQ-013 SHALL, on each Clk, load the EX record from the ID inputs, or a bubble (valid=0, regwrite=0, memread=0) when flush_idex=1.
REQ-014 SHALL drive ForwardA_sel/ForwardB_sel from flops; they are computed in ID and valid for the whole cycle the instruction occupies EX (one-cycle latency).
REQ-015 SHALL register next-cycle sel as 1 when the source is used, the current EX record is valid, regwrite=1, rd!=0 and rd equals the source.
REQ-016 SHALL otherwise register next-cycle sel as 2 when the same conditions hold against the current MEM record.
REQ-017 SHALL give EX/MEM priority over MEM/WB when both match; otherwise sel 0; values 3-7 never driven.
REQ-018 SHALL never forward register 0, and never forward from a source whose use flag is 0.
REQ-019 SHALL assert stall and flush_idex combinationally in the same cycle when id_valid=1, the EX record is a valid load (memread=1, regwrite=1, rd!=0) and rd matches a used id_rs or id_rt.
REQ-020 SHALL use FSM states RUN and BUBBLE: RUN->BUBBLE on load-use detection, BUBBLE->RUN unconditionally next cycle; stall is never asserted in BUBBLE.
REQ-021 SHALL, for the re-presented instruction in the cycle after a stall, forward the load result with sel=2 (load now in MEM).
REQ-022 SHALL register sel=0 for any instruction entering EX as a bubble.
REQ-023 SHALL increment stall_count by 1 per stall cycle, saturating at 16'hFFFF.
REQ-024 SHALL ignore all inputs when id_valid=0, except that records still advance.
REQ-025 SHALL NOT handle WB-to-ID hazards; the register file is write-before-read.

Reset
REQ-026 SHALL, while Rst=1 at a Clk edge, clear all stage records to bubbles, set FSM to RUN, set ForwardA_sel=ForwardB_sel=0 and stall_count=0.
REQ-027 SHALL hold stall=0 and flush_idex=0 during the cycle Rst is high and the first cycle after it; a reset mid-stall aborts the stall.

Structure
REQ-028 SHALL place sel encodings (SEL_RF=0, SEL_EXMEM=1, SEL_MEMWB=2), FSM state encodings and the stage-record layout in shared package pipe_ctrl_pkg.
REQ-029 SHALL instantiate one sub-module, fwd_compare, used twice (A and B), that maps {source, use flag, EX record, MEM record} to a 3-bit sel.

Verification
REQ-030 SHALL check: add $3 in EX, next ID uses rs=$3 -> ForwardA_sel=1 the next cycle, stall=0.
REQ-031 SHALL check: $5 written two instructions back, rt=$5 -> ForwardB_sel=2; with $5 written by both previous instructions -> ForwardB_sel=1.
REQ-032 SHALL check: lw $8 in EX, ID add uses rs=$8 -> stall=1, flush_idex=1 for exactly one cycle, then ForwardA_sel=2, stall_count=1.
REQ-033 SHALL check: writes to $0, or matching rt with id_uses_rt=0 -> sel stays 0, no stall.
REQ-034 SHALL check: Rst asserted during load-use stall -> next cycle stall=0, sels=0, stall_count=0.
REQ-035 SHALL check: 65540 consecutive load-use pairs -> stall_count saturates at 16'hFFFF.
